// File: rtl/memory_access_stage.sv
// Memory access stage: passes ALU results through to writeback and runs
// load/store transactions on a req/ack data-memory port, with a wait-cycle
// timeout. Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN -- when
// defined, misaligned half/word accesses trap (error pulse, no memory
// request); when undefined they are silently aligned.
module memory_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_size,
  input  logic        in_mem_unsigned,
  input  logic        in_dest_register_enable,
  input  logic [4:0]  in_dest_register_number,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic        out_dest_register_enable,
  output logic [4:0]  out_dest_register_number,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        error
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Captured access attributes, held for the whole transaction
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_we;
  logic        r_dest_en;
  logic [4:0]  r_dest_num;
  logic [WW-1:0] r_wait;

  // Registered outputs
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_dest_en;
  logic [4:0]  r_out_dest_num;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_be;
  logic        r_error;

  logic        w_is_mem;
  logic        w_trap;
  logic        w_timeout;
  logic        w_stall;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_is_mem  = in_mem_read | in_mem_write;
  // Timeout fires on the MAX_WAIT-th BUSY cycle without an ack
  assign w_timeout = (r_state == S_BUSY) && !dmem_ack && (r_wait == WW'(MAX_WAIT - 1));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((in_mem_size == 2'b01) && in_alu_result[0]) ||
                      ((in_mem_size == 2'b10) && (in_alu_result[1:0] != 2'b00));
  assign w_trap = w_misalign;
`else
  // Misaligned accesses are aligned by simply ignoring the low address bits
  assign w_trap = 1'b0;
`endif

  // Store lane replication and byte enables, derived from the live inputs at accept
  always_comb begin
    w_wdata = in_store_data;
    w_be    = 4'b1111;
    case (in_mem_size)
      2'b00: begin
        w_wdata = {4{in_store_data[7:0]}};
        w_be    = 4'b0001 << in_alu_result[1:0];
      end
      2'b01: begin
        w_wdata = {2{in_store_data[15:0]}};
        w_be    = 4'b0011 << {in_alu_result[1], 1'b0};
      end
      default: begin
        w_wdata = in_store_data;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Load lane selection and sign/zero extension from the captured address
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_data = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid && w_is_mem) w_state_next = w_trap ? S_DONE : S_BUSY;
      S_BUSY:  if (dmem_ack || w_timeout) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: stall rises combinationally in the accept cycle so upstream holds at once
  always_comb begin
    w_stall = 1'b0;
    if (reset) begin
      w_stall = ((r_state == S_IDLE) && in_valid && w_is_mem) || (r_state == S_BUSY);
    end
    stall                    = w_stall;
    out_valid                = r_out_valid;
    out_result               = r_out_result;
    out_dest_register_enable = r_out_dest_en;
    out_dest_register_number = r_out_dest_num;
    dmem_req                 = r_dmem_req;
    dmem_we                  = r_dmem_we;
    dmem_addr                = r_dmem_addr;
    dmem_wdata               = r_dmem_wdata;
    dmem_be                  = r_dmem_be;
    error                    = r_error;
  end

  // Datapath: capture on accept, drive the memory port, produce the writeback result
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr         <= '0;
      r_size         <= '0;
      r_uns          <= 1'b0;
      r_we           <= 1'b0;
      r_dest_en      <= 1'b0;
      r_dest_num     <= '0;
      r_wait         <= '0;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_dest_en  <= 1'b0;
      r_out_dest_num <= '0;
      r_dmem_req     <= 1'b0;
      r_dmem_we      <= 1'b0;
      r_dmem_addr    <= '0;
      r_dmem_wdata   <= '0;
      r_dmem_be      <= '0;
      r_error        <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out_valid   <= 1'b0;
          r_out_dest_en <= 1'b0;
          if (in_valid && !w_is_mem) begin
            r_out_valid    <= 1'b1;
            r_out_result   <= in_alu_result;
            r_out_dest_en  <= in_dest_register_enable;
            r_out_dest_num <= in_dest_register_number;
          end else if (in_valid) begin
            r_addr     <= in_alu_result;
            r_size     <= in_mem_size;
            r_uns      <= in_mem_unsigned;
            r_we       <= in_mem_write;
            r_dest_en  <= in_dest_register_enable;
            r_dest_num <= in_dest_register_number;
            r_wait     <= '0;
            if (w_trap) begin
              // Trapped access skips the memory and reports the faulting address
              r_out_valid    <= 1'b1;
              r_out_result   <= in_alu_result;
              r_out_dest_en  <= 1'b0;
              r_out_dest_num <= in_dest_register_number;
              r_error        <= 1'b1;
            end else begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= in_mem_write;
              r_dmem_addr  <= {in_alu_result[31:2], 2'b00};
              r_dmem_wdata <= w_wdata;
              r_dmem_be    <= in_mem_write ? w_be : 4'b1111;
            end
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_dmem_req     <= 1'b0;
            r_out_valid    <= 1'b1;
            r_out_result   <= r_we ? r_addr : w_load_data;
            r_out_dest_en  <= r_dest_en & ~r_we;
            r_out_dest_num <= r_dest_num;
          end else if (w_timeout) begin
            r_dmem_req     <= 1'b0;
            r_out_valid    <= 1'b1;
            r_out_result   <= r_addr;
            r_out_dest_en  <= 1'b0;
            r_out_dest_num <= r_dest_num;
            r_error        <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
          r_out_valid   <= 1'b0;
          r_out_dest_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: table of ALU/load/store
// vectors driven through a task, results checked by a negedge scoreboard
// monitor, plus hand-written reset, idle-ack and timeout sequences.
module tb_memory_access_stage;
  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [1:0]  in_mem_size;
  logic        in_mem_unsigned;
  logic        in_dest_register_enable;
  logic [4:0]  in_dest_register_number;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_dest_register_enable;
  logic [4:0]  out_dest_register_number;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        error;

  always #5 clk = ~clk;

  memory_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .in_dest_register_enable(in_dest_register_enable),
    .in_dest_register_number(in_dest_register_number),
    .out_valid(out_valid), .out_result(out_result),
    .out_dest_register_enable(out_dest_register_enable),
    .out_dest_register_number(out_dest_register_number),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        den;
    logic [4:0]  rdn;
    logic        er;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_dly;   // BUSY cycle carrying the ack; 0 = never ack
    logic        den;
    logic [4:0]  rdn;
    logic [31:0] exp_res;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_den;
    logic        misal;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  // Scoreboard monitor: every out_valid pops one expected writeback record
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got result %0h, expected no output", out_result);
      end else begin
        mon_e = sb.pop_front();
        chk("out_result", out_result, mon_e.res);
        chk("out_dest_en", out_dest_register_enable, mon_e.den);
        chk("out_dest_num", out_dest_register_number, mon_e.rdn);
        chk("error_pulse", error, mon_e.er);
        chk("out_cycle", cyc, mon_e.at);
      end
    end else begin
      chk("error_idle", error, 1'b0);
    end
  end

  function automatic logic [110:0] all_outs();
    return {out_valid, out_result, out_dest_register_enable, out_dest_register_number,
            stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, error};
  endfunction

  task automatic drive(input vec_t v);
    in_valid                = 1'b1;
    in_alu_result           = v.addr;
    in_store_data           = v.sdata;
    in_mem_read             = v.rd;
    in_mem_write            = v.wr;
    in_mem_size             = v.size;
    in_mem_unsigned         = v.uns;
    in_dest_register_enable = v.den;
    in_dest_register_number = v.rdn;
    dmem_rdata              = v.rdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic mem;
    logic trap;
    int   lat;
    int   stall_n;
    int   busy_n;
    int   c;
    exp_t e;
    mem  = v.rd | v.wr;
    trap = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    trap = v.misal;
`endif
    e.res = v.exp_res;
    e.den = v.exp_den;
    e.rdn = v.rdn;
    e.er  = 1'b0;
    if (mem && (trap || v.ack_dly == 0)) begin
      e.res = v.addr;
      e.den = 1'b0;
      e.er  = 1'b1;
    end
    if (!mem || trap)      lat = 0;
    else if (v.ack_dly == 0) lat = MAX_WAIT;
    else                   lat = v.ack_dly;
    e.at = cyc + 1 + lat;
    drive(v);
    sb.push_back(e);
    #1;
    chk($sformatf("v%0d_accept_stall", idx), stall, mem);
    if (!mem) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      stall_n = 0;
      busy_n  = 0;
      for (c = 0; c < 60; c++) begin
        if (c > 0 && !stall) break;
        if (stall) stall_n++;
        if (dmem_req) begin
          busy_n++;
          if (busy_n == 1) begin
            chk($sformatf("v%0d_dmem_addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_dmem_we", idx), dmem_we, v.wr);
            chk($sformatf("v%0d_dmem_be", idx), dmem_be, v.exp_be);
            if (v.wr) chk($sformatf("v%0d_dmem_wdata", idx), dmem_wdata, v.exp_wdata);
          end
          if (busy_n == v.ack_dly) dmem_ack = 1'b1;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (c == 0) begin
          // Upstream garbage while stalled must not be sampled
          in_alu_result           = ~v.addr;
          in_dest_register_number = ~v.rdn;
          in_mem_size             = ~v.size;
        end
      end
      chk($sformatf("v%0d_done_reached", idx), (c < 60), 1'b1);
      chk($sformatf("v%0d_stall_cycles", idx), stall_n, 1 + lat);
      chk($sformatf("v%0d_busy_cycles", idx), busy_n, trap ? 0 : lat);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rd   wr   size  uns  addr          sdata         rdata         ack den rdn    exp_res       be       wdata         eden misal
    vecs[0]  = '{1'b0,1'b0,2'd2,1'b0,32'h0000_1234,32'h0,        32'h0,        0, 1'b1,5'd5, 32'h0000_1234,4'hF,   32'h0,        1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b0,2'd2,1'b0,32'hDEAD_BEEF,32'h0,        32'h0,        0, 1'b0,5'd31,32'hDEAD_BEEF,4'hF,   32'h0,        1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,2'd0,1'b0,32'h0000_0103,32'h0,        32'h80FF_0000,1, 1'b1,5'd7, 32'hFFFF_FF80,4'hF,   32'h0,        1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b0,2'd0,1'b1,32'h0000_0101,32'h0,        32'h1234_8765,2, 1'b1,5'd8, 32'h0000_0087,4'hF,   32'h0,        1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b0,2'd1,1'b0,32'h0000_0102,32'h0,        32'h9ABC_1234,1, 1'b1,5'd9, 32'hFFFF_9ABC,4'hF,   32'h0,        1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,2'd1,1'b1,32'h0000_0100,32'h0,        32'h9ABC_8001,3, 1'b1,5'd3, 32'h0000_8001,4'hF,   32'h0,        1'b1,1'b0};
    vecs[6]  = '{1'b1,1'b0,2'd2,1'b0,32'h0000_0204,32'h0,        32'hCAFE_F00D,1, 1'b1,5'd4, 32'hCAFE_F00D,4'hF,   32'h0,        1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,2'd1,1'b0,32'h0000_0102,32'h1234_ABCD,32'h0,        4, 1'b1,5'd10,32'h0000_0102,4'b1100,32'hABCD_ABCD,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,2'd0,1'b0,32'h0000_0301,32'h0000_00A5,32'h0,        2, 1'b1,5'd11,32'h0000_0301,4'b0010,32'hA5A5_A5A5,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,2'd2,1'b0,32'h0000_040C,32'h1122_3344,32'h0,        1, 1'b0,5'd12,32'h0000_040C,4'hF,   32'h1122_3344,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,2'd0,1'b0,32'h0000_0102,32'h0,        32'h007F_0000,1, 1'b1,5'd13,32'h0000_007F,4'hF,   32'h0,        1'b1,1'b0};
    vecs[11] = '{1'b1,1'b0,2'd2,1'b0,32'h0000_0202,32'h0,        32'h5566_7788,1, 1'b1,5'd14,32'h5566_7788,4'hF,   32'h0,        1'b1,1'b1};
    vecs[12] = '{1'b1,1'b0,2'd1,1'b0,32'h0000_0103,32'h0,        32'h8000_1111,2, 1'b1,5'd15,32'hFFFF_8000,4'hF,   32'h0,        1'b1,1'b1};
    vecs[13] = '{1'b0,1'b1,2'd1,1'b0,32'h0000_0101,32'h0000_BEEF,32'h0,        1, 1'b1,5'd16,32'h0000_0101,4'b0011,32'hBEEF_BEEF,1'b0,1'b1};
    vecs[14] = '{1'b1,1'b0,2'd2,1'b0,32'h0000_0500,32'h0,        32'h0,        0, 1'b1,5'd17,32'h0,        4'hF,   32'h0,        1'b0,1'b0};

    // Reset held with a pending request and ack: everything must stay zero
    reset = 1'b0; in_valid = 1'b1; in_alu_result = 32'h123; in_store_data = 32'h0;
    in_mem_read = 1'b1; in_mem_write = 1'b0; in_mem_size = 2'd2; in_mem_unsigned = 1'b0;
    in_dest_register_enable = 1'b1; in_dest_register_number = 5'd1;
    dmem_rdata = 32'h0; dmem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), '0);
    in_valid = 1'b0; in_mem_read = 1'b0; dmem_ack = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", all_outs(), '0);

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Idle after an ALU op clears valid/dest enable; acks in IDLE are ignored
    run_vec(100, vecs[0]);
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_dest_en", out_dest_register_enable, 1'b0);
      chk("idle_ack_no_req", {stall, dmem_req}, 2'b00);
    end
    dmem_ack = 1'b0;

    // Reset arriving together with the ack abandons the access
    drive(vecs[6]);
    @(posedge clk); #1;
    chk("mid_busy_req", dmem_req, 1'b1);
    in_valid = 1'b0;
    dmem_ack = 1'b1;
    reset    = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_access", all_outs(), '0);
    reset    = 1'b1;
    dmem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("after_reset_no_valid", {out_valid, dmem_req, stall}, 3'b000);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, maximum cycles dmem_req stays high without dmem_ack before timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports in_valid 1, in_alu_result 32 (address or ALU result), in_store_data 32, in_mem_read 1, in_mem_write 1, in_mem_size 2 (00 byte, 01 half, 10 word), in_mem_unsigned 1, in_dest_register_enable 1, in_dest_register_number 5, all inputs from ALU stage.
REQ-005 SHALL have outputs out_valid 1, out_result 32, out_dest_register_enable 1, out_dest_register_number 5, all feeding writeback.
REQ-006 SHALL have output stall 1, high while a memory access is outstanding; upstream holds its inputs while high.
REQ-007 SHALL have data-memory ports dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_be out 4, dmem_rdata in 32, dmem_ack in 1.
REQ-008 SHALL have output error 1, a one-cycle pulse on timeout or trap.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-010 In IDLE with in_valid=1 and neither in_mem_read nor in_mem_write, SHALL register inputs with 1-cycle latency: out_valid=1, out_result=in_alu_result, dest fields passed through; stall stays 0.
REQ-011 In IDLE with in_valid=1 and in_mem_read or in_mem_write, SHALL capture inputs, go to BUSY next cycle, and drive stall=1 in that same accept cycle and throughout BUSY.
REQ-012 In BUSY SHALL hold dmem_req=1, dmem_addr={addr[31:2],2'b00}, dmem_we=in_mem_write (captured), all stable until dmem_ack.
REQ-013 Stores SHALL replicate data into lanes: byte -> 4 copies of [7:0], half -> 2 copies of [15:0], word as-is; dmem_be: byte 4'b0001<<addr[1:0], half 4'b0011<<{addr[1],1'b0}, word 4'b1111. Reads drive dmem_be=4'b1111.
REQ-014 On dmem_ack in BUSY SHALL drop dmem_req next cycle, enter DONE, and latch the load result.
REQ-015 Load result SHALL select a byte by addr[1:0] or a half by addr[1], then sign-extend (in_mem_unsigned=0) or zero-extend (=1); word loads return dmem_rdata unchanged.
REQ-016 In DONE SHALL present out_valid=1 for exactly one cycle, deassert stall, and return to IDLE. Loads: out_result = extended data. Stores: out_result = address, and out_dest_register_enable=0.
REQ-017 Minimum memory-op latency SHALL be 3 cycles from accept to out_valid when dmem_ack arrives on the first BUSY cycle.
REQ-018 When in_valid=0 in IDLE, SHALL drive out_valid=0 and out_dest_register_enable=0.
REQ-019 A BUSY wait counter SHALL increment each cycle without dmem_ack.
REQ-020 When the wait counter reaches MAX_WAIT, SHALL drop dmem_req, pulse error, go to DONE with out_dest_register_enable=0.
REQ-021 dmem_ack outside BUSY SHALL be ignored.
REQ-022 Inputs presented while stall=1 SHALL NOT be sampled.

Reset
REQ-023 With reset=0 at a clock edge, SHALL enter IDLE and clear the wait counter.
REQ-024 Reset SHALL drive these outputs to 0: out_valid, out_result, out_dest_register_enable, out_dest_register_number, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, error.
REQ-025 Reset SHALL take priority over a simultaneous dmem_ack or in_valid.
REQ-026 Reset mid-access SHALL abandon the outstanding request without producing out_valid.

Configuration
REQ-027 With MEM_STAGE_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no dmem_req, pulse error, and complete via DONE in 2 cycles with out_dest_register_enable=0.
REQ-028 Without MEM_STAGE_MISALIGN_TRAP_EN, misaligned accesses SHALL be silently aligned: half uses addr[1], word ignores addr[1:0]; error is never raised for misalignment.

Verification
REQ-029 ALU-only op, in_alu_result=0x0000_1234, rd=5 -> next cycle out_valid=1, out_result=0x1234, rd=5, stall never high.
REQ-030 Signed byte load, addr 0x103, dmem_rdata=0x80FF_0000, ack on first BUSY cycle -> out_result=0xFFFF_FF80, out_valid on cycle 3.
REQ-031 Store half, addr 0x102, data 0xABCD, ack after 4 cycles -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x100, stall high 5 cycles, out_dest_register_enable=0.
REQ-032 dmem_ack never asserted, MAX_WAIT=16 -> dmem_req drops after 16 BUSY cycles, error pulses once, stall clears.
REQ-033 Word load at 0x202 with macro defined -> no dmem_req, error pulse; without macro -> dmem_addr=0x200, normal completion.
REQ-034 reset=0 on the cycle dmem_ack arrives -> IDLE, all outputs 0, no out_valid afterwards.
